// File: rtl/alu_lockstep_scheduler.sv
// Shares a dual-lane lockstep 4-bit ALU between two requesters.
// Grants round-robin, drives identical operands to both lanes, waits the ALU
// latency, compares the lanes and retries on mismatch up to MAX_RETRY times.
// Ports:
//   wb_clk_i, wb_rst_i        clock, async active-high reset
//   req_valid/req_ready       per-requester request handshake (ready is combinational)
//   req_a0/b0/sel0, a1/b1/sel1 requester operands and ALU select
//   rsp_valid/rsp_ready       per-requester response handshake
//   rsp_data/carry/err        lane-1 result, lane-1 carry, final-compare mismatch
//   alu_a/alu_b/alu_sel       operands fanned to both lanes
//   alu_out1/2, alu_cout1/2   lane results
//   mismatch_cnt, clr_cnt     saturating mismatch count and its synchronous clear
//   busy                      high whenever not IDLE
module alu_lockstep_scheduler #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [3:0]       req_a0,
    input  logic [3:0]       req_b0,
    input  logic [1:0]       req_sel0,
    input  logic [3:0]       req_a1,
    input  logic [3:0]       req_b1,
    input  logic [1:0]       req_sel1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [3:0]       rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_sel,
    input  logic [3:0]       alu_out1,
    input  logic [3:0]       alu_out2,
    input  logic             alu_cout1,
    input  logic             alu_cout2,
    output logic [CNT_W-1:0] mismatch_cnt,
    input  logic             clr_cnt,
    output logic             busy
);

    localparam int unsigned LAT_W = (ALU_LATENCY > 0) ? $clog2(ALU_LATENCY + 1) : 1;
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t             state_q, state_d;
    logic               gnt_q, gnt_d;
    logic               last_q, last_d;
    logic [LAT_W-1:0]   wait_q, wait_d;
    logic [RTY_W-1:0]   retry_q, retry_d;
    logic [3:0]         alu_a_q, alu_a_d;
    logic [3:0]         alu_b_q, alu_b_d;
    logic [1:0]         alu_sel_q, alu_sel_d;
    logic [1:0]         rsp_valid_q, rsp_valid_d;
    logic [3:0]         rsp_data_q, rsp_data_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [1:0]         req_ready_c;
    logic               gnt_sel_c;
    logic               mismatch_c;

    // Both valid: alternate away from the last served requester; otherwise take the one asking.
    always_comb begin
        gnt_sel_c = 1'b0;
        if (req_valid == 2'b11) gnt_sel_c = ~last_q;
        else                    gnt_sel_c = req_valid[1];
    end

    assign mismatch_c = (alu_out1 != alu_out2) || (alu_cout1 != alu_cout2);

    // Next-state and datapath updates.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        wait_d      = wait_q;
        retry_d     = retry_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_err_d   = rsp_err_q;
        cnt_d       = cnt_q;
        req_ready_c = 2'b00;

        case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    req_ready_c[gnt_sel_c] = 1'b1;
                    gnt_d     = gnt_sel_c;
                    alu_a_d   = gnt_sel_c ? req_a1   : req_a0;
                    alu_b_d   = gnt_sel_c ? req_b1   : req_b0;
                    alu_sel_d = gnt_sel_c ? req_sel1 : req_sel0;
                    wait_d    = LAT_W'(ALU_LATENCY);
                    retry_d   = '0;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (wait_q != '0) begin
                    wait_d = wait_q - LAT_W'(1);
                end else begin
                    if (mismatch_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
                    if (mismatch_c && (retry_q < RTY_W'(MAX_RETRY))) begin
                        retry_d = retry_q + RTY_W'(1);
                        wait_d  = LAT_W'(ALU_LATENCY);
                    end else begin
                        rsp_data_d  = alu_out1;
                        rsp_carry_d = alu_cout1;
                        rsp_err_d   = mismatch_c;
                        rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
                        state_d     = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready[gnt_q]) begin
                    rsp_valid_d = 2'b00;
                    last_d      = gnt_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear wins over a same-cycle increment.
        if (clr_cnt) cnt_d = '0;

        busy_d = (state_d != IDLE);
    end

    // State and output registers; last_q resets to 1 so requester 0 wins first contention.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            gnt_q       <= 1'b0;
            last_q      <= 1'b1;
            wait_q      <= '0;
            retry_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            wait_q      <= wait_d;
            retry_q     <= retry_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_err_q   <= rsp_err_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign req_ready    = req_ready_c;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_carry    = rsp_carry_q;
    assign rsp_err      = rsp_err_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_sel      = alu_sel_q;
    assign mismatch_cnt = cnt_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_alu_lockstep_scheduler.sv
// Directed bench for alu_lockstep_scheduler (ALU_LATENCY=1, MAX_RETRY=2, CNT_W=2).
// The bench plays both ALU lanes by driving alu_out*/alu_cout* directly.
module tb_alu_lockstep_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req_valid, req_ready;
    logic [3:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] req_sel0, req_sel1;
    logic [1:0] rsp_valid, rsp_ready;
    logic [3:0] rsp_data;
    logic       rsp_carry, rsp_err;
    logic [3:0] alu_a, alu_b;
    logic [1:0] alu_sel;
    logic [3:0] alu_out1, alu_out2;
    logic       alu_cout1, alu_cout2;
    logic [1:0] mismatch_cnt;
    logic       clr_cnt;
    logic       busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_lockstep_scheduler #(.ALU_LATENCY(1), .MAX_RETRY(2), .CNT_W(2)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_b0(req_b0), .req_sel0(req_sel0),
        .req_a1(req_a1), .req_b1(req_b1), .req_sel1(req_sel1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out1(alu_out1), .alu_out2(alu_out2),
        .alu_cout1(alu_cout1), .alu_cout2(alu_cout2),
        .mismatch_cnt(mismatch_cnt), .clr_cnt(clr_cnt), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00; clr_cnt = 1'b0;
        req_a0 = 4'h0; req_b0 = 4'h0; req_sel0 = 2'd0;
        req_a1 = 4'h0; req_b1 = 4'h0; req_sel1 = 2'd0;
        alu_out1 = 4'h0; alu_out2 = 4'h0; alu_cout1 = 1'b0; alu_cout2 = 1'b0;
        tick(); tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL reset_rsp_valid got=%0h exp=0", rsp_valid); end
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL reset_req_ready got=%0h exp=0", req_ready); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        total++; if ({alu_a, alu_b, alu_sel} !== 10'h0) begin bad++; $display("FAIL reset_alu got=%0h exp=0", {alu_a, alu_b, alu_sel}); end
        total++; if ({rsp_data, rsp_carry, rsp_err} !== 6'h0) begin bad++; $display("FAIL reset_rsp got=%0h exp=0", {rsp_data, rsp_carry, rsp_err}); end
        total++; if (mismatch_cnt !== 2'd0) begin bad++; $display("FAIL reset_cnt got=%0h exp=0", mismatch_cnt); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        alu_out1 = 4'h1; alu_out2 = 4'h1; alu_cout1 = 1'b1; alu_cout2 = 1'b1;
        req_a0 = 4'h9; req_b0 = 4'h8; req_sel0 = 2'd0; req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL single_req_ready got=%0h exp=1", req_ready); end
        tick();
        req_valid = 2'b00;
        total++; if ({alu_a, alu_b, alu_sel} !== {4'h9, 4'h8, 2'd0}) begin bad++; $display("FAIL single_alu_ops got=%0h exp=%0h", {alu_a, alu_b, alu_sel}, {4'h9, 4'h8, 2'd0}); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%0h exp=1", busy); end
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL single_early_valid got=%0h exp=0", rsp_valid); end
        tick();
        total++; if (rsp_valid !== 2'b01) begin bad++; $display("FAIL single_rsp_valid got=%0h exp=1", rsp_valid); end
        total++; if ({rsp_data, rsp_carry, rsp_err} !== {4'h1, 1'b1, 1'b0}) begin bad++; $display("FAIL single_rsp got=%0h exp=%0h", {rsp_data, rsp_carry, rsp_err}, {4'h1, 1'b1, 1'b0}); end
        total++; if (mismatch_cnt !== 2'd0) begin bad++; $display("FAIL single_cnt got=%0h exp=0", mismatch_cnt); end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        total++; if ({rsp_valid, busy} !== 3'b000) begin bad++; $display("FAIL single_done got=%0h exp=0", {rsp_valid, busy}); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_g;
        rst = 1'b1; #1; rst = 1'b0;
        alu_out1 = 4'h5; alu_out2 = 4'h5; alu_cout1 = 1'b0; alu_cout2 = 1'b0;
        req_a0 = 4'h1; req_a1 = 4'h2; req_valid = 2'b11; rsp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            total++; if (req_ready !== exp_g) begin bad++; $display("FAIL cont_grant%0d got=%0h exp=%0h", i, req_ready, exp_g); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL cont_idle_busy%0d got=%0h exp=0", i, busy); end
            tick();
            total++; if ({busy, alu_a} !== {1'b1, (i % 2 == 0) ? 4'h1 : 4'h2}) begin bad++; $display("FAIL cont_exec%0d got=%0h", i, {busy, alu_a}); end
            tick(); tick();
            total++; if ({rsp_valid, rsp_data} !== {exp_g, 4'h5}) begin bad++; $display("FAIL cont_rsp%0d got=%0h exp=%0h", i, {rsp_valid, rsp_data}, {exp_g, 4'h5}); end
            tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        #1;
    endtask

    task automatic test_transient();
        alu_out1 = 4'h3; alu_out2 = 4'h7; alu_cout1 = 1'b0; alu_cout2 = 1'b0;
        req_valid = 2'b01;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL trans_req_ready got=%0h exp=1", req_ready); end
        tick();
        req_valid = 2'b00;
        tick(); tick();
        alu_out2 = 4'h3;
        total++; if ({rsp_valid, mismatch_cnt} !== {2'b00, 2'd1}) begin bad++; $display("FAIL trans_retry got=%0h exp=1", {rsp_valid, mismatch_cnt}); end
        tick();
        total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL trans_early_valid got=%0h exp=0", rsp_valid); end
        tick();
        total++; if ({rsp_valid, rsp_data, rsp_err} !== {2'b01, 4'h3, 1'b0}) begin bad++; $display("FAIL trans_rsp got=%0h exp=%0h", {rsp_valid, rsp_data, rsp_err}, {2'b01, 4'h3, 1'b0}); end
        total++; if (mismatch_cnt !== 2'd1) begin bad++; $display("FAIL trans_cnt got=%0h exp=1", mismatch_cnt); end
        rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    endtask

    task automatic test_persistent();
        clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
        total++; if (mismatch_cnt !== 2'd0) begin bad++; $display("FAIL pers_clear got=%0h exp=0", mismatch_cnt); end
        alu_out1 = 4'h4; alu_out2 = 4'h4; alu_cout1 = 1'b1; alu_cout2 = 1'b0;
        for (int t = 0; t < 2; t++) begin
            req_valid = 2'b01;
            tick();
            req_valid = 2'b00;
            repeat (5) tick();
            total++; if (rsp_valid !== 2'b00) begin bad++; $display("FAIL pers_early%0d got=%0h exp=0", t, rsp_valid); end
            tick();
            total++; if ({rsp_valid, rsp_data, rsp_carry, rsp_err} !== {2'b01, 4'h4, 1'b1, 1'b1}) begin bad++; $display("FAIL pers_rsp%0d got=%0h exp=%0h", t, {rsp_valid, rsp_data, rsp_carry, rsp_err}, {2'b01, 4'h4, 1'b1, 1'b1}); end
            total++; if (mismatch_cnt !== 2'd3) begin bad++; $display("FAIL pers_cnt%0d got=%0h exp=3", t, mismatch_cnt); end
            rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
        end
    endtask

    task automatic test_back_to_back();
        alu_out1 = 4'hA; alu_out2 = 4'hA; alu_cout1 = 1'b1; alu_cout2 = 1'b1;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b10) begin bad++; $display("FAIL bp_grant got=%0h exp=2", req_ready); end
        tick(); tick(); tick();
        total++; if ({rsp_valid, rsp_data} !== {2'b10, 4'hA}) begin bad++; $display("FAIL bp_rsp got=%0h exp=%0h", {rsp_valid, rsp_data}, {2'b10, 4'hA}); end
        rsp_ready = 2'b01;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++; if ({rsp_valid, rsp_data, req_ready} !== {2'b10, 4'hA, 2'b00}) begin bad++; $display("FAIL bp_hold%0d got=%0h exp=%0h", c, {rsp_valid, rsp_data, req_ready}, {2'b10, 4'hA, 2'b00}); end
        end
        rsp_ready = 2'b10; tick(); rsp_ready = 2'b00;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL bp_next_grant got=%0h exp=1", req_ready); end
        alu_out1 = 4'h1; alu_out2 = 4'h2; alu_cout1 = 1'b0; alu_cout2 = 1'b0;
        tick();
        req_valid = 2'b00;
        tick();
        clr_cnt = 1'b1;
        tick();
        clr_cnt = 1'b0;
        total++; if (mismatch_cnt !== 2'd0) begin bad++; $display("FAIL clr_priority got=%0h exp=0", mismatch_cnt); end
        alu_out2 = 4'h1;
        tick(); tick();
        total++; if ({rsp_valid, rsp_data, rsp_err, mismatch_cnt} !== {2'b01, 4'h1, 1'b0, 2'd0}) begin bad++; $display("FAIL clr_rsp got=%0h exp=%0h", {rsp_valid, rsp_data, rsp_err, mismatch_cnt}, {2'b01, 4'h1, 1'b0, 2'd0}); end
        rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    endtask

    task automatic test_reset_exec();
        alu_out1 = 4'h1; alu_out2 = 4'h2; alu_cout1 = 1'b0; alu_cout2 = 1'b0;
        req_a0 = 4'hF; req_b0 = 4'hE; req_sel0 = 2'd3; req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick(); tick();
        total++; if ({mismatch_cnt, busy, alu_a} !== {2'd1, 1'b1, 4'hF}) begin bad++; $display("FAIL rexec_pre got=%0h exp=%0h", {mismatch_cnt, busy, alu_a}, {2'd1, 1'b1, 4'hF}); end
        #2; rst = 1'b1; #1;
        total++; if ({rsp_valid, req_ready, busy} !== 5'h0) begin bad++; $display("FAIL rexec_ctrl got=%0h exp=0", {rsp_valid, req_ready, busy}); end
        total++; if ({alu_a, alu_b, alu_sel, rsp_data, rsp_carry, rsp_err, mismatch_cnt} !== 18'h0) begin bad++; $display("FAIL rexec_data got=%0h exp=0", {alu_a, alu_b, alu_sel, rsp_data, rsp_carry, rsp_err, mismatch_cnt}); end
        rst = 1'b0;
        tick();
        total++; if ({rsp_valid, busy} !== 3'b000) begin bad++; $display("FAIL rexec_after got=%0h exp=0", {rsp_valid, busy}); end
        alu_out1 = 4'h6; alu_out2 = 4'h6;
        req_valid = 2'b11;
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rexec_grant got=%0h exp=1", req_ready); end
        tick();
        req_valid = 2'b00;
        tick(); tick();
        total++; if ({rsp_valid, rsp_data} !== {2'b01, 4'h6}) begin bad++; $display("FAIL rexec_rsp got=%0h exp=%0h", {rsp_valid, rsp_data}, {2'b01, 4'h6}); end
        rsp_ready = 2'b01; tick(); rsp_ready = 2'b00;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_transient();
        test_persistent();
        test_back_to_back();
        test_reset_exec();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_lockstep_scheduler.md
Name: alu_lockstep_scheduler

Overview:
- Sequences and shares the dual-lane lockstep 4-bit ALU datapath (two identical ALU lanes plus their compare outputs) between two requesters: port 0 (Wishbone-side firmware) and port 1 (IO-pad side).
- Grants round-robin and drives identical operands and select to both lanes.
- Waits the ALU latency, then compares the lanes. On mismatch it retries up to MAX_RETRY times and returns the result with an error flag.
- Keeps a saturating count of lane mismatches for the logic analyser.

Parameters:
- ALU_LATENCY, 1, clock edges from operand registers to valid ALU outputs (≥0)
- MAX_RETRY, 2, additional attempts after a mismatch (0 = no retry)
- CNT_W, 8, mismatch counter width

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid
- req_ready  out  2  per-requester accept (one-hot, combinational)
- req_a0 / req_b0  in  4 each  requester-0 operands
- req_sel0  in  2  requester-0 ALU select
- req_a1 / req_b1  in  4 each  requester-1 operands
- req_sel1  in  2  requester-1 ALU select
- rsp_valid  out  2  per-requester response valid (one-hot)
- rsp_ready  in  2  per-requester response accept
- rsp_data  out  4  result (lane-1 output)
- rsp_carry  out  1  lane-1 carry
- rsp_err  out  1  final attempt mismatched
- alu_a, alu_b  out  4 each  operands, fanned to both lanes by top level
- alu_sel  out  2  select, fanned to both lanes
- alu_out1, alu_out2  in  4 each  lane results
- alu_cout1, alu_cout2  in  1 each  lane carries
- mismatch_cnt  out  CNT_W  saturating count of mismatching compares
- clr_cnt  in  1  synchronous clear of mismatch_cnt
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync release). State goes to IDLE.
  - All outputs are 0: req_ready, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b, alu_sel, mismatch_cnt and busy.
  - Retry count is 0. The round-robin pointer favours requester 0.
  - A reset mid-transaction drops the transaction with no response.
- States are IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, grant one requester. If both are high, grant the one not granted last; after reset, requester 0 wins.
  - req_ready[g] is high combinationally in IDLE only.
  - On the accept edge, register operands and select onto alu_*, load the wait counter with ALU_LATENCY, clear the retry count, and go to EXEC.
- alu_a, alu_b and alu_sel hold stable from the accept edge until the next accept.
- EXEC:
  - While the counter is nonzero, decrement it each edge.
  - When the counter is 0, sample the lanes on that edge:
    - Mismatch is (alu_out1≠alu_out2) OR (alu_cout1≠alu_cout2).
    - On mismatch, increment mismatch_cnt, saturating at all-ones.
    - Mismatch with retry count < MAX_RETRY: increment the retry count, reload the counter, stay in EXEC. Operands are unchanged.
    - Otherwise: register rsp_data=alu_out1, rsp_carry=alu_cout1, rsp_err=mismatch; go to RESP.
- Latency: rsp_valid rises (ALU_LATENCY+1) edges after the accept edge. Each retry adds ALU_LATENCY+1 edges.
- RESP:
  - rsp_valid[g] is high. rsp_data, rsp_carry and rsp_err are held.
  - On the rsp_ready[g] edge: clear rsp_valid, record g as last granted, go to IDLE.
  - rsp_ready[g] may already be high when rsp_valid rises; the handshake then completes on the first RESP edge.
  - rsp_ready on the non-granted bit is ignored.
- No new request is accepted until IDLE. A new accept can occur in the cycle after the RESP handshake edge.
- clr_cnt has priority over a same-cycle increment; the counter reads 0 afterwards.

Test Plan:
- Single request, ALU_LATENCY=1:
  - Stimulus: req0 a=9, b=8, sel=0; bench lanes return out1=out2=1, cout=1.
  - Response: req_ready[0] in cycle 0; alu_a=9, alu_b=8 from edge 1; rsp_valid[0] after edge 2 with data=1, carry=1, err=0; mismatch_cnt=0.
- Contention:
  - Stimulus: req_valid=2'b11 held; lanes match.
  - Response: grants go 0,1,0,1. rsp_valid is one-hot to the matching requester. busy drops for exactly one cycle between transactions.
- Transient fault:
  - Stimulus: lanes mismatch (out1=3, out2=7) on the first compare only.
  - Response: one retry; rsp_valid after edge 4; data=3, err=0; mismatch_cnt=1.
- Persistent fault, MAX_RETRY=2:
  - Stimulus: lanes always mismatch on carry.
  - Response: three compares; rsp_err=1; mismatch_cnt=3. With CNT_W=2 over repeated transactions, mismatch_cnt saturates at 3.
- Back-pressure and clear:
  - Stimulus: hold rsp_ready=0 for 5 cycles, then pulse clr_cnt in the same cycle as a mismatch compare.
  - Response: rsp_valid and rsp_data stay stable and no new req_ready appears; mismatch_cnt=0 after the clear.
- Async reset asserted in EXEC:
  - Response: all outputs 0 immediately, with no rsp_valid. After release, requester 0 wins a simultaneous request.
